// File: rtl/btn_event_decoder.sv
// btn_event_decoder
//   Classifies each debounced button level into short-press, long-press and
//   auto-repeat one-clock pulses. Every button has its own small FSM and its
//   own tick counter; buttons never interact. All outputs are registered.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   tick          one-clock timing strobe; counters advance only on tick
//   btn_level     debounced, clk-synchronous levels, 1 = pressed
//   short_pulse   1-clk pulse: press released before LONG_TICKS ticks
//   long_pulse    1-clk pulse: press reached LONG_TICKS ticks
//   repeat_pulse  1-clk pulse every REPEAT_TICKS ticks after long_pulse
//   held          level: button is in the long-press state
module btn_event_decoder #(
   parameter int unsigned BTN_WIDTH    = 4,
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned LONG_TICKS   = 1000,
   parameter int unsigned REPEAT_TICKS = 200,
   parameter bit          REPEAT_EN    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic [BTN_WIDTH-1:0] btn_level,
   output logic [BTN_WIDTH-1:0] short_pulse,
   output logic [BTN_WIDTH-1:0] long_pulse,
   output logic [BTN_WIDTH-1:0] repeat_pulse,
   output logic [BTN_WIDTH-1:0] held
);

   localparam logic [1:0] ST_WAIT_REL = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_PRESSED  = 2'd2;
   localparam logic [1:0] ST_LONG     = 2'd3;

   // Terminal counts: the counter never goes past these, so it cannot wrap.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
   localparam logic             REP_VAL   = REPEAT_EN;

   for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
      logic [1:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             short_q, short_d;
      logic             long_q, long_d;
      logic             rep_q, rep_d;
      logic             held_q;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         short_d = 1'b0;
         long_d  = 1'b0;
         rep_d   = 1'b0;
         unique case (state_q)
            // A button held through reset must be released before it counts.
            ST_WAIT_REL: begin
               if (!btn_level[i]) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               cnt_d = '0;
               if (btn_level[i]) state_d = ST_PRESSED;
            end
            // Release has priority over a tick on the same edge.
            ST_PRESSED: begin
               if (!btn_level[i]) begin
                  short_d = 1'b1;
                  state_d = ST_IDLE;
               end else if (tick) begin
                  if (cnt_q == LONG_LAST) begin
                     long_d  = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_LONG;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_LONG: begin
               if (!btn_level[i]) begin
                  state_d = ST_IDLE;
               end else if (tick) begin
                  if (cnt_q == REP_LAST) begin
                     rep_d = REP_VAL;
                     cnt_d = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_WAIT_REL;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= (state_d == ST_LONG);
         end
      end

      assign short_pulse[i]  = short_q;
      assign long_pulse[i]   = long_q;
      assign repeat_pulse[i] = rep_q;
      assign held[i]         = held_q;
   end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Testbench for btn_event_decoder: directed scenarios followed by random
// button activity, checked every cycle against a tick-counting reference
// model. A second instance built with REPEAT_EN=0 shares the stimulus.
module tb_btn_event_decoder;
   localparam int LT = 4;
   localparam int RT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [3:0] btn;
   logic [3:0] sp_a, lp_a, rp_a, hd_a;
   logic [3:0] sp_b, lp_b, rp_b, hd_b;

   int total = 0;
   int bad   = 0;
   int phase = 0;

   // Reference model state: ticks counted since the press edge.
   bit   wait_rel [4];
   bit   active   [4];
   int   nticks   [4];
   logic [3:0] e_sp, e_lp, e_rp, e_hd;

   always #5 clk = ~clk;

   btn_event_decoder #(
      .BTN_WIDTH(4), .CNT_W(10), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_level(btn),
      .short_pulse(sp_a), .long_pulse(lp_a), .repeat_pulse(rp_a), .held(hd_a)
   );

   btn_event_decoder #(
      .BTN_WIDTH(4), .CNT_W(10), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b0)
   ) dut_norep (
      .clk(clk), .rst(rst), .tick(tick), .btn_level(btn),
      .short_pulse(sp_b), .long_pulse(lp_b), .repeat_pulse(rp_b), .held(hd_b)
   );

   task automatic model_step();
      e_sp = '0;
      e_lp = '0;
      e_rp = '0;
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            wait_rel[i] = 1'b1;
            active[i]   = 1'b0;
            nticks[i]   = 0;
         end else if (wait_rel[i]) begin
            if (!btn[i]) wait_rel[i] = 1'b0;
         end else if (!active[i]) begin
            if (btn[i]) begin
               active[i] = 1'b1;
               nticks[i] = 0;
            end
         end else if (!btn[i]) begin
            e_sp[i]   = (nticks[i] < LT);
            active[i] = 1'b0;
         end else if (tick) begin
            nticks[i]++;
            if (nticks[i] == LT) e_lp[i] = 1'b1;
            if (nticks[i] > LT && ((nticks[i] - LT) % RT) == 0) e_rp[i] = 1'b1;
         end
         e_hd[i] = active[i] && (nticks[i] >= LT);
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("short", sp_a, e_sp);
      chk("long", lp_a, e_lp);
      chk("repeat", rp_a, e_rp);
      chk("held", hd_a, e_hd);
      chk("norep_short", sp_b, e_sp);
      chk("norep_long", lp_b, e_lp);
      chk("norep_repeat", rp_b, 4'b0000);
      chk("norep_held", hd_b, e_hd);
   endtask

   // One clock: drive tick, let the edge happen, update model, sample at +1.
   task automatic cycle();
      tick  = (phase == 3);
      phase = (phase + 1) % 4;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   int n_short;
   int tk;

   initial begin
      rst  = 1'b1;
      btn  = 4'b0000;
      tick = 1'b0;
      #2;
      run(3);
      chk("reset_outputs", sp_a | lp_a | rp_a | hd_a, 4'b0000);
      rst = 1'b0;
      run(4);

      // 1: short press on btn[0].
      btn[0] = 1'b1;
      run(6);
      btn[0] = 1'b0;
      cycle();
      chk("s1_short0", sp_a, 4'b0001);
      run(4);

      // 2: long press with repeats on btn[1].
      btn[1] = 1'b1;
      run(30);
      chk("s2_held1", hd_a, 4'b0010);
      btn[1] = 1'b0;
      cycle();
      chk("s2_release", sp_a | hd_a, 4'b0000);
      run(4);

      // 3: release of btn[2] coincides with the 4th tick.
      btn[2] = 1'b1;
      cycle();
      tk = 0;
      for (int k = 0; k < 40; k++) begin
         if (phase == 3 && tk == LT - 1) break;
         cycle();
         if (tick) tk++;
      end
      btn[2] = 1'b0;
      cycle();
      chk("s3_short2", sp_a, 4'b0100);
      chk("s3_nolong", lp_a, 4'b0000);
      run(4);

      // 4: btn[3] held through reset, then a short re-press.
      btn[3] = 1'b1;
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      n_short = 0;
      for (int k = 0; k < 24; k++) begin
         cycle();
         if (sp_a[3] || lp_a[3] || hd_a[3]) n_short++;
      end
      btn[3] = 1'b0;
      run(2);
      btn[3] = 1'b1;
      run(8);
      btn[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (sp_a[3]) n_short++;
      end
      total++;
      assert (n_short == 1) else begin
         bad++;
         $error("FAIL s4_events observed=%0d expected=1", n_short);
      end

      // 5: simultaneous presses on btn[0] and btn[1].
      btn = 4'b0011;
      run(5);
      btn = 4'b0000;
      cycle();
      chk("s5_short01", sp_a, 4'b0011);
      run(3);

      // 6: reset mid-long-press on btn[1] with the button still held.
      btn[1] = 1'b1;
      run(24);
      rst = 1'b1;
      cycle();
      chk("s6_rst_out", sp_a | lp_a | rp_a | hd_a, 4'b0000);
      rst = 1'b0;
      run(24);
      btn[1] = 1'b0;
      run(2);
      btn[1] = 1'b1;
      run(30);
      btn[1] = 1'b0;
      run(4);

      // Random activity with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
         rst = ($urandom_range(0, 399) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
